multi_monitor: RTL
==================

MULTI_MONITOR -- requirements
Module: multi_monitor

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each channel counter (2..16).
REQ-002 Parameter CHANNELS, default 4: number of independent device-group channels (1..16).
REQ-003 Parameter SATURATE, default 0: 0 = wrap-around counting, 1 = clamp at 0 and at 2^WIDTH-1.
REQ-004 Port list:
  - clk, input, 1: single clock; all state updates on its rising edge.
  - rst, input, 1: synchronous, active-high reset.
  - change, input, CHANNELS: per-channel count enable.
  - on_off, input, CHANNELS: per-channel direction; 1 = up, 0 = down.
  - flag_clr, input, CHANNELS: per-channel clear of the sticky flags.
  - threshold, input, WIDTH: alarm level, common to all channels.
  - counter_out, output, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
  - total_out, output, WIDTH+clog2(CHANNELS) (minimum WIDTH+1): registered sum of all channel counters.
  - alarm, output, CHANNELS: channel counter >= threshold.
  - ovf_flag, output, CHANNELS: sticky; set by an up-step attempted from 2^WIDTH-1.
  - unf_flag, output, CHANNELS: sticky; set by a down-step attempted from 0.

Function
REQ-005 Channel counter: holds its value when change[i]=0.
REQ-006 Channel counter: when change[i]=1, steps +1 if on_off[i]=1 and -1 if on_off[i]=0, in the same clock edge.
REQ-007 SATURATE=0: an up-step from 2^WIDTH-1 yields 0; a down-step from 0 yields 2^WIDTH-1.
REQ-008 SATURATE=1: an up-step from 2^WIDTH-1 holds the value; a down-step from 0 holds 0.
REQ-009 ovf_flag[i] is set on the edge where an up-step is applied at the maximum value, in either mode; unf_flag[i] likewise for a down-step applied at 0.
REQ-010 flag_clr[i] clears both flags of channel i on the next edge; a set condition on the same edge takes priority, so the flag stays 1.
REQ-011 Channels are fully independent; simultaneous change on any subset of channels is legal.
REQ-012 alarm[i] is combinational from the registered counter and the current threshold; it is valid in the same cycle as counter_out.
REQ-013 total_out equals the sum of all counter_out values from the previous cycle (one-cycle latency); no wrap is possible at the defined width.
REQ-014 All outputs are driven from flops, except alarm (REQ-012).

Reset
REQ-015 When rst=1 on a clock edge, all counters, total_out, ovf_flag and unf_flag SHALL become 0 on that edge.
REQ-016 rst SHALL override change and flag_clr on the same edge.
REQ-017 Reset mid-count SHALL give a clean zero state: on the first edge after rst is released, total_out SHALL be 0, not a stale sum.
REQ-018 After reset, alarm SHALL equal (threshold == 0) for all channels.

Structure
REQ-019 Package monitor_pkg SHALL hold the SATURATE mode constants (MODE_WRAP=0, MODE_SAT=1) and the clog2-based total-width function.
REQ-020 Sub-module monitor_channel (one counter, its flags and its alarm compare) SHALL be instantiated CHANNELS times through a generate loop.
REQ-021 The top level SHALL contain only the channel array, output packing and the registered summation.

Verification (WIDTH=8, CHANNELS=4)
REQ-022 rst=1, then change=4'b1111 and on_off=4'b1111 for 3 cycles -> counter_out every channel = 3; total_out = 12 one cycle later.
REQ-023 SATURATE=0: ch0 at 255, up-step -> ch0 = 0, ovf_flag[0]=1; flag_clr[0] pulse -> ovf_flag[0]=0 next edge.
REQ-024 SATURATE=1: ch1 at 0, down-step -> ch1 stays 0, unf_flag[1]=1; at 255, up-step -> stays 255, ovf_flag[1]=1.
REQ-025 threshold=5: ch2 counts up from 0 -> alarm[2] rises in the cycle counter_out shows 5; one down-step -> alarm[2]=0.
REQ-026 Flag priority: flag_clr[3]=1 on the same edge as an overflow at 255 -> ovf_flag[3] remains 1.
REQ-027 Reset mid-count: counters at {10,20,30,40}, rst=1 with change=4'b1111 -> all counters 0; total_out 0 on the following cycle.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared constants and helpers for the multi-channel up/down monitor.
// Mode encodings for the SATURATE parameter and the width of the channel sum.
package monitor_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Wide enough that CHANNELS * (2^width - 1) can never wrap; always at least one extra bit.
   function automatic int total_width(input int width, input int channels);
      int extra;
      extra = $clog2(channels);
      if (extra < 1) begin
         extra = 1;
      end
      return width + extra;
   endfunction

endpackage

// File: rtl/monitor_channel.sv
// One monitored channel: up/down counter with wrap or clamp behaviour,
// sticky overflow/underflow flags and a combinational threshold alarm.
module monitor_channel
   import monitor_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             change_i,
   input  logic             up_i,
   input  logic             flag_clr_i,
   input  logic [WIDTH-1:0] threshold_i,
   output logic [WIDTH-1:0] count_o,
   output logic             alarm_o,
   output logic             ovf_o,
   output logic             unf_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             at_max, at_zero;
   logic             ovf_evt, unf_evt;

   always_comb begin
      at_max  = &count_q;
      at_zero = ~|count_q;
      ovf_evt = change_i & up_i & at_max;
      unf_evt = change_i & ~up_i & at_zero;

      count_d = count_q;
      if (change_i) begin
         // In clamp mode a step past either end leaves the count untouched.
         if ((ovf_evt || unf_evt) && (SATURATE == MODE_SAT)) begin
            count_d = count_q;
         end else if (up_i) begin
            count_d = count_q + WIDTH'(1);
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end

      // A new event wins over a clear on the same edge.
      ovf_d = ovf_evt | (ovf_q & ~flag_clr_i);
      unf_d = unf_evt | (unf_q & ~flag_clr_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count_o = count_q;
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;
   assign alarm_o = (count_q >= threshold_i);

endmodule

// File: rtl/multi_monitor.sv
// Array of independent monitor channels with packed outputs and a
// registered sum of all channel counts (one cycle behind counter_out).
module multi_monitor
   import monitor_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [CHANNELS-1:0]                       change,
   input  logic [CHANNELS-1:0]                       on_off,
   input  logic [CHANNELS-1:0]                       flag_clr,
   input  logic [WIDTH-1:0]                          threshold,
   output logic [CHANNELS*WIDTH-1:0]                 counter_out,
   output logic [total_width(WIDTH, CHANNELS)-1:0]   total_out,
   output logic [CHANNELS-1:0]                       alarm,
   output logic [CHANNELS-1:0]                       ovf_flag,
   output logic [CHANNELS-1:0]                       unf_flag
);

   localparam int TOTAL_W = total_width(WIDTH, CHANNELS);

   logic [WIDTH-1:0]   count_w [CHANNELS];
   logic [TOTAL_W-1:0] total_q, total_d;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         monitor_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
         ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .change_i    (change[gi]),
            .up_i        (on_off[gi]),
            .flag_clr_i  (flag_clr[gi]),
            .threshold_i (threshold),
            .count_o     (count_w[gi]),
            .alarm_o     (alarm[gi]),
            .ovf_o       (ovf_flag[gi]),
            .unf_o       (unf_flag[gi])
         );
         assign counter_out[gi*WIDTH +: WIDTH] = count_w[gi];
      end
   endgenerate

   always_comb begin
      total_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         total_d = total_d + TOTAL_W'(count_w[i]);
      end
   end

   // Reset clears the sum too, so the first cycle after reset never shows a stale total.
   always_ff @(posedge clk) begin
      if (rst) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign total_out = total_q;

endmodule
